// File: rtl/clock_pkg.sv
// Shared clock-domain types: field widths, wrap limits, field-select codes and the
// time-set FSM state enum, plus small helpers for field wrap arithmetic.
package clock_pkg;

    localparam int HR_W = 5;
    localparam int MS_W = 6;

    localparam logic [HR_W-1:0] HR_MAX = 5'd23;
    localparam logic [MS_W-1:0] MS_MAX = 6'd59;

    localparam logic [1:0] FSEL_NONE = 2'd0;
    localparam logic [1:0] FSEL_HR   = 2'd1;
    localparam logic [1:0] FSEL_MIN  = 2'd2;
    localparam logic [1:0] FSEL_SEC  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_HR,
        ST_EDIT_MIN,
        ST_EDIT_SEC,
        ST_COMMIT
    } state_t;

    function automatic logic is_edit(input state_t s);
        return (s == ST_EDIT_HR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            ST_EDIT_HR:  return FSEL_HR;
            ST_EDIT_MIN: return FSEL_MIN;
            ST_EDIT_SEC: return FSEL_SEC;
            default:     return FSEL_NONE;
        endcase
    endfunction

    // >= rather than == so an out-of-range captured value still wraps sanely
    function automatic logic [HR_W-1:0] wrap_hr(input logic [HR_W-1:0] v, input logic up);
        if (up) return (v >= HR_MAX) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? HR_MAX : v - 5'd1;
    endfunction

    function automatic logic [MS_W-1:0] wrap_ms(input logic [MS_W-1:0] v, input logic up);
        if (up) return (v >= MS_MAX) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? MS_MAX : v - 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stable-count debouncer -> one-cycle press pulse.
// Level settles 2+DEBOUNCE_CYCLES edges after a clean change; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            level_d <= level_q;
            // any sample that agrees with the current level restarts the count
            if (sync_q2 != level_q) begin
                if (cnt == CNT_LAST) begin
                    level_q <= sync_q2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_d;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hr/min/sec editor producing a one-cycle set_time load for the clock core.
// Actions land one edge after a debounced press; buttons are sampled freely, no backpressure.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_RATE     = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            btn_dec,
    input  logic [HR_W-1:0] cur_hr,
    input  logic [MS_W-1:0] cur_min,
    input  logic [MS_W-1:0] cur_sec,
    output logic            set_time,
    output logic [HR_W-1:0] hr_out,
    output logic [MS_W-1:0] min_out,
    output logic [MS_W-1:0] sec_out,
    output logic            editing,
    output logic [1:0]      field_sel
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] REP_FIRE_AT = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD  = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    logic mode_lvl_unused;
    logic mode_ev;
    logic inc_lvl;
    logic inc_ev;
    logic dec_lvl;
    logic dec_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .level (mode_lvl_unused),
        .press (mode_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .level (inc_lvl),
        .press (inc_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_dec),
        .level (dec_lvl),
        .press (dec_ev)
    );

    state_t          state;
    state_t          state_nx;
    logic [HR_W-1:0] hr_q;
    logic [MS_W-1:0] min_q;
    logic [MS_W-1:0] sec_q;
    logic [HR_W-1:0] hr_nx;
    logic [MS_W-1:0] min_nx;
    logic [MS_W-1:0] sec_nx;
    logic [RW-1:0]   rep_cnt;
    logic [TW-1:0]   to_cnt;

    logic in_edit;
    logic held;
    logic rep_fire;
    logic any_ev;
    logic timed_out;
    logic step_up;
    logic step_dn;

    always_comb begin
        state_nx  = state;
        hr_nx     = hr_q;
        min_nx    = min_q;
        sec_nx    = sec_q;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        in_edit   = is_edit(state);
        held      = inc_lvl ^ dec_lvl;
        rep_fire  = in_edit && held && (rep_cnt == REP_FIRE_AT);
        any_ev    = mode_ev | inc_ev | dec_ev | rep_fire;
        timed_out = in_edit && !any_ev && (to_cnt == TO_LAST);

        case (state)
            ST_IDLE:     if (mode_ev) state_nx = ST_EDIT_HR;
            ST_EDIT_HR:  if (mode_ev) state_nx = ST_EDIT_MIN;
                         else if (timed_out) state_nx = ST_IDLE;
            ST_EDIT_MIN: if (mode_ev) state_nx = ST_EDIT_SEC;
                         else if (timed_out) state_nx = ST_IDLE;
            ST_EDIT_SEC: if (mode_ev) state_nx = ST_COMMIT;
                         else if (timed_out) state_nx = ST_IDLE;
            ST_COMMIT:   state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase

        // mode wins over a coincident step; simultaneous inc+dec cancels
        if (in_edit && !mode_ev) begin
            step_up = (inc_ev & ~dec_ev) | (rep_fire & inc_lvl);
            step_dn = (dec_ev & ~inc_ev) | (rep_fire & dec_lvl);
        end

        if (state == ST_IDLE && mode_ev) begin
            hr_nx  = cur_hr;
            min_nx = cur_min;
            sec_nx = cur_sec;
        end else if (step_up || step_dn) begin
            case (state)
                ST_EDIT_HR:  hr_nx  = wrap_hr(hr_q, step_up);
                ST_EDIT_MIN: min_nx = wrap_ms(min_q, step_up);
                ST_EDIT_SEC: sec_nx = wrap_ms(sec_q, step_up);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            set_time  <= 1'b0;
            editing   <= 1'b0;
            field_sel <= FSEL_NONE;
            hr_q      <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            rep_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nx;
            set_time  <= (state_nx == ST_COMMIT);
            editing   <= is_edit(state_nx);
            field_sel <= field_of(state_nx);
            hr_q      <= hr_nx;
            min_q     <= min_nx;
            sec_q     <= sec_nx;

            // rep_cnt = cycles since the step press; only a press arms it
            if (!in_edit || !held || mode_ev)
                rep_cnt <= '0;
            else if (inc_ev || dec_ev)
                rep_cnt <= {{(RW-1){1'b0}}, 1'b1};
            else if (rep_fire)
                rep_cnt <= REP_RELOAD;
            else if (rep_cnt != '0)
                rep_cnt <= rep_cnt + 1'b1;

            if (!in_edit || any_ev)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign hr_out  = hr_q;
    assign min_out = min_q;
    assign sec_out = sec_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed + randomized bench for time_set_ctrl against a press-level reference model.
module tb_time_set_ctrl;

    localparam int RD = 8;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [4:0] cur_hr;
    logic [5:0] cur_min, cur_sec;
    logic       set_time;
    logic [4:0] hr_out;
    logic [5:0] min_out, sec_out;
    logic       editing;
    logic [1:0] field_sel;

    time_set_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_hr    (cur_hr),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .set_time  (set_time),
        .hr_out    (hr_out),
        .min_out   (min_out),
        .sec_out   (sec_out),
        .editing   (editing),
        .field_sel (field_sel)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: selected field (0 = idle) and edit values
    int m_field = 0, m_hr = 0, m_min = 0, m_sec = 0;
    int exp_pulse = 0;

    int         pulse_cnt = 0;
    logic [4:0] pulse_hr  = '0;
    logic [5:0] pulse_min = '0, pulse_sec = '0;
    logic       st_prev   = 1'b0;
    logic [4:0] hr_prev   = '0;
    logic [5:0] min_prev  = '0, sec_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (set_time) begin
            pulse_cnt++;
            pulse_hr  = hr_out;
            pulse_min = min_out;
            pulse_sec = sec_out;
            chk("pulse_single", 32'(st_prev), 32'd0);
            chk("pulse_hr_stable", 32'(hr_out), 32'(hr_prev));
            chk("pulse_min_stable", 32'(min_out), 32'(min_prev));
            chk("pulse_sec_stable", 32'(sec_out), 32'(sec_prev));
        end
        st_prev  = set_time;
        hr_prev  = hr_out;
        min_prev = min_out;
        sec_prev = sec_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nsteps(input int hold);
        return 1 + ((hold > RD) ? ((hold - 1 - RD) / RR + 1) : 0);
    endfunction

    function automatic int step_mod(input int v, input int n, input int m, input bit up);
        return up ? (v + n) % m : (((v - n) % m) + m) % m;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_field"}, 32'(field_sel), m_field);
        chk({tag, "_editing"}, 32'(editing), 32'(m_field != 0));
        chk({tag, "_hr"}, 32'(hr_out), m_hr);
        chk({tag, "_min"}, 32'(min_out), m_min);
        chk({tag, "_sec"}, 32'(sec_out), m_sec);
        chk({tag, "_pulses"}, pulse_cnt, exp_pulse);
    endtask

    // hold raw button clean for 'hold' cycles, then allow the release to settle
    task automatic do_press(input int which, input int hold, input string tag);
        int n;
        case (which)
            0:       btn_mode = 1'b1;
            1:       btn_inc  = 1'b1;
            default: btn_dec  = 1'b1;
        endcase
        repeat (hold) tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (12) tick();
        if (m_field == 0) begin
            if (which == 0) begin
                m_hr = int'(cur_hr); m_min = int'(cur_min); m_sec = int'(cur_sec);
                m_field = 1;
            end
        end else if (which == 0) begin
            if (m_field == 3) begin
                exp_pulse++;
                m_field = 0;
                chk({tag, "_commit_hr"}, 32'(pulse_hr), m_hr);
                chk({tag, "_commit_min"}, 32'(pulse_min), m_min);
                chk({tag, "_commit_sec"}, 32'(pulse_sec), m_sec);
            end else begin
                m_field++;
            end
        end else begin
            n = nsteps(hold);
            case (m_field)
                1:       m_hr  = step_mod(m_hr, n, 24, which == 1);
                2:       m_min = step_mod(m_min, n, 60, which == 1);
                default: m_sec = step_mod(m_sec, n, 60, which == 1);
            endcase
        end
        check_model(tag);
    endtask

    initial begin
        int n, changes;
        int chg_t[$];
        int exp_t[7];
        logic [1:0] fprev;
        logic [5:0] mprev;

        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_hr = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        repeat (3) tick();
        chk("rst_set_time", 32'(set_time), 32'd0);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_field", 32'(field_sel), 32'd0);
        chk("rst_hr", 32'(hr_out), 32'd0);
        chk("rst_min", 32'(min_out), 32'd0);
        chk("rst_sec", 32'(sec_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // press latency: field_sel changes on edge 7 after first sample
        btn_mode = 1'b1;
        repeat (6) tick();
        chk("lat_edge6_field", 32'(field_sel), 32'd0);
        tick();
        chk("lat_edge7_field", 32'(field_sel), 32'd1);
        chk("lat_edge7_editing", 32'(editing), 32'd1);
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (12) tick();
        m_field = 1; m_hr = 12; m_min = 34; m_sec = 56;
        check_model("capture");
        do_press(0, 5, "t1_m1");
        do_press(0, 5, "t1_m2");
        do_press(0, 5, "t1_commit");

        // full sequence with hour wrap
        cur_hr = 5'd23; cur_min = 6'd34; cur_sec = 6'd56;
        do_press(0, 5, "seq_enter");
        do_press(1, 5, "seq_hr_wrap");
        chk("seq_hr_is0", 32'(hr_out), 32'd0);
        do_press(0, 5, "seq_to_min");
        do_press(2, 5, "seq_min_dec");
        do_press(0, 5, "seq_to_sec");
        do_press(0, 5, "seq_commit");
        chk("seq_pulse_min", 32'(pulse_min), 32'd33);

        // bounce: 1100110011 then held high
        cur_hr = 5'd10; cur_min = 6'd58; cur_sec = 6'd0;
        fprev = field_sel; changes = 0;
        for (int i = 0; i < 34; i++) begin
            if (i < 10)       btn_mode = ((i % 4) < 2);
            else if (i < 22)  btn_mode = 1'b1;
            else              btn_mode = 1'b0;
            tick();
            if (field_sel != fprev) begin changes++; fprev = field_sel; end
        end
        chk("bounce_changes", changes, 32'd1);
        m_field = 1; m_hr = 10; m_min = 58; m_sec = 0;
        check_model("bounce");
        do_press(0, 5, "rep_to_min");

        // auto-repeat: inc held 20 cycles from 58
        exp_t = '{7, 15, 17, 19, 21, 23, 25};
        mprev = min_out;
        btn_inc = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 20) btn_inc = 1'b0;
            if (min_out != mprev) begin chg_t.push_back(i); mprev = min_out; end
        end
        chk("rep_num_steps", chg_t.size(), 32'd7);
        for (int k = 0; k < 7; k++)
            if (k < chg_t.size()) chk($sformatf("rep_step%0d_time", k), chg_t[k], exp_t[k]);
        m_min = step_mod(58, nsteps(20), 60, 1'b1);
        chk("rep_final_min", 32'(min_out), 32'd5);
        check_model("rep");

        // inc+dec together cancel
        btn_inc = 1'b1; btn_dec = 1'b1;
        repeat (6) tick();
        btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (12) tick();
        check_model("conf_incdec");

        // mode+inc together: field advances, no step; then time out in EDIT_SEC
        btn_mode = 1'b1; btn_inc = 1'b1;
        n = 0;
        while (field_sel != 2'd3 && n < 30) begin
            tick(); n++;
            if (n == 6) begin btn_mode = 1'b0; btn_inc = 1'b0; end
        end
        chk("conf_mode_edge", n, 32'd7);
        m_field = 3;
        check_model("conf_modeinc");
        n = 0;
        while (field_sel != 2'd0 && n < 200) begin tick(); n++; end
        chk("timeout_cycles", n, 32'd64);
        m_field = 0;
        check_model("timeout");

        // asynchronous reset mid EDIT_MIN
        cur_hr = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
        do_press(0, 5, "rst_enter");
        do_press(0, 5, "rst_to_min");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        m_field = 0; m_hr = 0; m_min = 0; m_sec = 0;
        check_model("midrst");
        chk("midrst_set_time", 32'(set_time), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_model("post_rst");

        // randomized presses against the model
        for (int it = 0; it < 30; it++) begin
            int which, hold;
            cur_hr  = 5'($urandom_range(0, 23));
            cur_min = 6'($urandom_range(0, 59));
            cur_sec = 6'($urandom_range(0, 59));
            which = $urandom_range(0, 2);
            hold  = (which == 0) ? 5 : $urandom_range(5, 28);
            do_press(which, hold, $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
